// File: rtl/game_pkg.sv
// Shared game-level types: game_state encodings, lane count, judge FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Used by hit_judge and its edge detector; the game_state encodings are the same
// ones the score counter and the top-level game FSM decode.
package game_pkg;

    localparam int LANES = 2;

    // Encodings carried on the 2-bit game_state bus.
    typedef enum logic [1:0] {
        GS_IDLE        = 2'd0,
        GS_SONG_SELECT = 2'd1,
        GS_GAME_PLAY   = 2'd2,
        GS_GAME_OVER   = 2'd3
    } game_state_t;

    // Judge FSM: IDLE = not playing, WAIT = playing with no window, OPEN = window open.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OPEN = 2'd2
    } judge_state_t;

endpackage

// File: rtl/edge_rise.sv
// Per-lane rising-edge detector on clk-synchronous level inputs.
// Latency: combinational rise against a one-cycle registered copy of d.
// Backpressure: none; a held level yields a single rise.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset (previous value clears to 0)
//   d    - level inputs, one bit per lane
//   rise - high for the cycle where d goes 0 -> 1
module edge_rise
    import game_pkg::*;
#(
    parameter int W = LANES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] d_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_prev <= '0;
        end else begin
            d_prev <= d;
        end
    end

    assign rise = d & ~d_prev;

endmodule

// File: rtl/hit_judge.sv
// Judges lane button presses against chart notes inside a tick-counted window; tracks combo.
// Latency: judgement and combo update are registered, visible one cycle after the window closes.
// Backpressure: none; outputs are one-cycle pulses, the downstream scorer must accept every cycle.
//
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   game_state   - GS_* encoding; the judge only runs in GS_GAME_PLAY
//   tick_en      - one-cycle game-time tick, advances the window counter
//   note_stb     - note reaches the hit line; note_lanes sampled with it
//   btn          - debounced lane buttons (level)
//   hit_lanes    - one-cycle judgement: lanes hit correctly, 0 otherwise
//   judge_valid  - one-cycle pulse with every judgement
//   miss         - one-cycle pulse: at least one required lane was not hit
//   combo        - running combo, saturating at 255
//   max_combo    - best combo since GAME_PLAY was entered
module hit_judge
    import game_pkg::*;
#(
    parameter int WIN_TICKS = 8,
    parameter int WIN_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       game_state,
    input  logic             tick_en,
    input  logic             note_stb,
    input  logic [LANES-1:0] note_lanes,
    input  logic [LANES-1:0] btn,
    output logic [LANES-1:0] hit_lanes,
    output logic             judge_valid,
    output logic             miss,
    output logic [7:0]       combo,
    output logic [7:0]       max_combo
);

    judge_state_t     state;
    logic [LANES-1:0] req;
    logic [LANES-1:0] got;
    logic [WIN_W-1:0] cnt;

    logic [LANES-1:0] rise;
    logic             playing;
    logic [LANES-1:0] got_next;
    logic             all_hit;
    logic             expire;
    logic             close_win;
    logic             judge_miss;
    logic [7:0]       combo_nxt;
    logic [7:0]       max_nxt;

    edge_rise #(.W(LANES)) u_edge_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (btn),
        .rise (rise)
    );

    assign playing = (game_state == GS_GAME_PLAY);

    // Presses on lanes the note does not require are masked off here, so they
    // can neither score nor break the combo.
    assign got_next = got | (rise & req);
    assign all_hit  = (got_next == req);
    assign expire   = tick_en && (cnt == WIN_W'(WIN_TICKS - 1));

    // A new strobe always closes the current window, whatever its lanes.
    assign close_win = (state == ST_OPEN) && playing && (all_hit || expire || note_stb);

    always_comb begin
        judge_miss = (got_next != req);
        combo_nxt  = 8'd0;
        if (!judge_miss) begin
            combo_nxt = (combo == 8'hFF) ? 8'hFF : combo + 8'd1;
        end
        max_nxt = (combo_nxt > max_combo) ? combo_nxt : max_combo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req         <= '0;
            got         <= '0;
            cnt         <= '0;
            hit_lanes   <= '0;
            judge_valid <= 1'b0;
            miss        <= 1'b0;
            combo       <= 8'd0;
            max_combo   <= 8'd0;
        end else begin
            // Judgement outputs are pulses; only a closing window raises them.
            hit_lanes   <= '0;
            judge_valid <= 1'b0;
            miss        <= 1'b0;

            if (!playing) begin
                // Leaving play drops any open window unjudged; combo is kept
                // so the game-over screen can show it.
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_WAIT;
                        combo     <= 8'd0;
                        max_combo <= 8'd0;
                    end

                    ST_WAIT: begin
                        if (note_stb && (note_lanes != '0)) begin
                            req   <= note_lanes;
                            got   <= '0;
                            cnt   <= '0;
                            state <= ST_OPEN;
                        end
                    end

                    ST_OPEN: begin
                        if (close_win) begin
                            hit_lanes   <= got_next;
                            judge_valid <= 1'b1;
                            miss        <= judge_miss;
                            combo       <= combo_nxt;
                            max_combo   <= max_nxt;
                            // A strobe that closed the window immediately opens
                            // the next one, unless it carries no lanes.
                            if (note_stb && (note_lanes != '0)) begin
                                req   <= note_lanes;
                                got   <= '0;
                                cnt   <= '0;
                                state <= ST_OPEN;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end else begin
                            got <= got_next;
                            if (tick_en) begin
                                cnt <= cnt + WIN_W'(1);
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;
    import game_pkg::*;

    localparam int WIN_TICKS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] game_state;
    logic       tick_en;
    logic       note_stb;
    logic [1:0] note_lanes;
    logic [1:0] btn;
    logic [1:0] hit_lanes;
    logic       judge_valid;
    logic       miss;
    logic [7:0] combo;
    logic [7:0] max_combo;

    always #5 clk = ~clk;

    hit_judge #(.WIN_TICKS(WIN_TICKS), .WIN_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .game_state  (game_state),
        .tick_en     (tick_en),
        .note_stb    (note_stb),
        .note_lanes  (note_lanes),
        .btn         (btn),
        .hit_lanes   (hit_lanes),
        .judge_valid (judge_valid),
        .miss        (miss),
        .combo       (combo),
        .max_combo   (max_combo)
    );

    typedef struct packed {
        logic [1:0] hit;
        logic       mis;
        logic [7:0] cmb;
        logic [7:0] mx;
    } exp_t;

    typedef struct {
        logic [1:0] lanes;
        logic [1:0] press;
        int         delay;
        logic [1:0] hit;
        logic       mis;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   total = 0;
    int   bad   = 0;
    int   mdl_combo = 0;
    int   mdl_max   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Expected judgement plus the combo the bench's own counter predicts.
    task automatic push_exp(input logic [1:0] h, input logic m);
        exp_t e;
        if (m) mdl_combo = 0;
        else if (mdl_combo < 255) mdl_combo++;
        if (mdl_combo > mdl_max) mdl_max = mdl_combo;
        e.hit = h;
        e.mis = m;
        e.cmb = 8'(mdl_combo);
        e.mx  = 8'(mdl_max);
        sb.push_back(e);
    endtask

    // Inputs change on the falling edge and are held across one rising edge.
    task automatic step(input logic t, input logic s, input logic [1:0] l, input logic [1:0] b);
        tick_en    = t;
        note_stb   = s;
        note_lanes = l;
        btn        = b;
        @(negedge clk);
    endtask

    task automatic run_note(input logic [1:0] lanes, input logic [1:0] press, input int delay,
                            input logic [1:0] h, input logic m);
        push_exp(h, m);
        step(1'b0, 1'b1, lanes, 2'b00);
        for (int k = 0; k < WIN_TICKS; k++) begin
            if (k == delay) begin
                step(1'b0, 1'b0, 2'b00, press);
                step(1'b0, 1'b0, 2'b00, 2'b00);
            end
            step(1'b1, 1'b0, 2'b00, 2'b00);
        end
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    // Scoreboard: every judge pulse must match the oldest expectation; between
    // judgements the pulse outputs must stay low.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (judge_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_judge: got judge_valid=1 hit_lanes=%b want no judgement at %0t",
                             hit_lanes, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("judge_hit_lanes", 32'(hit_lanes), 32'(mon_e.hit));
                    check("judge_miss", 32'(miss), 32'(mon_e.mis));
                    check("judge_combo", 32'(combo), 32'(mon_e.cmb));
                    check("judge_max_combo", 32'(max_combo), 32'(mon_e.mx));
                end
            end else begin
                check("quiet_hit_lanes", 32'(hit_lanes), 32'd0);
                check("quiet_miss", 32'(miss), 32'd0);
            end
        end
    end

    initial begin
        // lanes, press, press delay (ticks), expected hit, expected miss
        vecs[0] = '{2'b01, 2'b01, 3, 2'b01, 1'b0};
        vecs[1] = '{2'b10, 2'b10, 0, 2'b10, 1'b0};
        vecs[2] = '{2'b11, 2'b11, 5, 2'b11, 1'b0};
        vecs[3] = '{2'b01, 2'b11, 1, 2'b01, 1'b0};
        vecs[4] = '{2'b10, 2'b10, 7, 2'b10, 1'b0};
        vecs[5] = '{2'b11, 2'b10, 4, 2'b10, 1'b1};
        vecs[6] = '{2'b01, 2'b00, 0, 2'b00, 1'b1};
        vecs[7] = '{2'b10, 2'b01, 2, 2'b00, 1'b1};
        vecs[8] = '{2'b01, 2'b01, 2, 2'b01, 1'b0};

        rst        = 1'b1;
        game_state = GS_IDLE;
        tick_en    = 1'b0;
        note_stb   = 1'b0;
        note_lanes = 2'b00;
        btn        = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("reset_hit_lanes", 32'(hit_lanes), 32'd0);
        check("reset_judge_valid", 32'(judge_valid), 32'd0);
        check("reset_miss", 32'(miss), 32'd0);
        check("reset_combo", 32'(combo), 32'd0);
        check("reset_max_combo", 32'(max_combo), 32'd0);
        rst = 1'b0;

        // Notes while idle are ignored.
        step(1'b0, 1'b1, 2'b01, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b01);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        game_state = GS_GAME_PLAY;
        step(1'b0, 1'b0, 2'b00, 2'b00);

        for (int i = 0; i < 9; i++) begin
            run_note(vecs[i].lanes, vecs[i].press, vecs[i].delay, vecs[i].hit, vecs[i].mis);
            check("vector_drained", 32'(sb.size()), 32'd0);
        end
        check("after_table_max_combo", 32'(max_combo), 32'd5);

        // Chord completed by a rise on the very tick that expires the window.
        push_exp(2'b11, 1'b0);
        step(1'b0, 1'b1, 2'b11, 2'b00);
        step(1'b1, 1'b0, 2'b00, 2'b01);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 2'b00, 2'b01);
        step(1'b1, 1'b0, 2'b00, 2'b11);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        // A strobe with no lanes opens nothing.
        step(1'b0, 1'b1, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b11);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        // Both lanes rise together -> early close; held buttons cannot hit the next note.
        push_exp(2'b11, 1'b0);
        step(1'b0, 1'b1, 2'b11, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b11);
        step(1'b0, 1'b0, 2'b00, 2'b11);
        step(1'b0, 1'b0, 2'b00, 2'b11);
        push_exp(2'b00, 1'b1);
        step(1'b0, 1'b1, 2'b11, 2'b11);
        for (int k = 0; k < WIN_TICKS; k++) step(1'b1, 1'b0, 2'b00, 2'b11);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        // Back-to-back: unpressed 01 window closed by a 10 strobe, then 10 hit.
        push_exp(2'b00, 1'b1);
        push_exp(2'b10, 1'b0);
        step(1'b0, 1'b1, 2'b01, 2'b00);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b1, 2'b10, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b10);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        // Rise on the closing strobe cycle counts for the old note.
        push_exp(2'b01, 1'b0);
        push_exp(2'b10, 1'b0);
        step(1'b0, 1'b1, 2'b01, 2'b00);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b1, 2'b10, 2'b01);
        step(1'b0, 1'b0, 2'b00, 2'b10);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        // Window closed by a lane-less strobe: judged, then nothing open.
        push_exp(2'b00, 1'b1);
        step(1'b0, 1'b1, 2'b10, 2'b00);
        step(1'b0, 1'b1, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b10);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Saturation.
        for (int i = 0; i < 260; i++) begin
            push_exp(2'b01, 1'b0);
            step(1'b0, 1'b1, 2'b01, 2'b00);
            step(1'b0, 1'b0, 2'b00, 2'b01);
            step(1'b0, 1'b0, 2'b00, 2'b00);
        end
        step(1'b0, 1'b0, 2'b00, 2'b00);
        check("sat_combo", 32'(combo), 32'd255);
        check("sat_max_combo", 32'(max_combo), 32'd255);

        // Leave play with a window open: no judgement, combo held.
        step(1'b0, 1'b1, 2'b10, 2'b00);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        game_state = GS_GAME_OVER;
        step(1'b0, 1'b0, 2'b00, 2'b10);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b1, 1'b1, 2'b01, 2'b01);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        check("over_combo_held", 32'(combo), 32'(mdl_combo));
        check("over_max_held", 32'(max_combo), 32'(mdl_max));

        // Re-entering play clears both counters.
        game_state = GS_GAME_PLAY;
        mdl_combo  = 0;
        mdl_max    = 0;
        step(1'b0, 1'b0, 2'b00, 2'b00);
        check("reenter_combo", 32'(combo), 32'd0);
        check("reenter_max_combo", 32'(max_combo), 32'd0);
        run_note(2'b01, 2'b01, 0, 2'b01, 1'b0);
        check("reenter_hit_combo", 32'(combo), 32'd1);

        // Async reset mid-window, coincident with a completing press.
        step(1'b0, 1'b1, 2'b01, 2'b00);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        btn = 2'b01;
        rst = 1'b1;
        #1;
        check("arst_combo", 32'(combo), 32'd0);
        check("arst_max_combo", 32'(max_combo), 32'd0);
        check("arst_hit_lanes", 32'(hit_lanes), 32'd0);
        check("arst_judge_valid", 32'(judge_valid), 32'd0);
        check("arst_miss", 32'(miss), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_combo = 0;
        mdl_max   = 0;
        step(1'b0, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        run_note(2'b10, 2'b10, 1, 2'b10, 1'b0);
        check("post_rst_combo", 32'(combo), 32'd1);

        // Bounded drain of any outstanding expectations.
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
